bitcoin_nonce_select: RTL and testbench

//  Downstream stage of the bitcoin hasher. Once the hasher has written NUM_NONCES
//  32-bit H0 words (one per nonce) to memory, this block reads them back and picks
//  the minimum hash and its nonce index. It compares that minimum against a target,

---
 rtl/bitcoin_nonce_select.sv | 115 +++++++++++
 tb/tb_bitcoin_nonce_select.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_nonce_select.sv
// rtl/bitcoin_nonce_select.sv - scans NUM_NONCES hash words, picks the minimum and writes a result record
module bitcoin_nonce_select #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [31:0] best_hash,
    output logic [7:0]  best_nonce,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, READ, WR_HASH, WR_IDX} state_t;

    localparam logic [8:0] LAST = 9'(NUM_NONCES);

    state_t      state;
    logic [15:0] base_addr;
    logic [15:0] res_addr;
    logic [31:0] tgt;
    logic [31:0] run_min;
    logic [7:0]  run_idx;
    logic [8:0]  cnt;

    logic        take;
    logic [31:0] next_min;
    logic [7:0]  next_idx;

    assign mem_clk = clk;

    // cnt=0 has no data yet; data arriving in cycle cnt belongs to index cnt-1
    always_comb begin
        take     = 1'b0;
        next_min = run_min;
        next_idx = run_idx;
        if (cnt != 9'd0 && mem_read_data < run_min) begin
            take     = 1'b1;
            next_min = mem_read_data;
            next_idx = 8'(cnt - 9'd1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            done           <= 1'b1;
            found          <= 1'b0;
            best_hash      <= 32'd0;
            best_nonce     <= 8'd0;
            mem_we         <= 1'b0;
            mem_addr       <= 16'd0;
            mem_write_data <= 32'd0;
            base_addr      <= 16'd0;
            res_addr       <= 16'd0;
            tgt            <= 32'd0;
            run_min        <= 32'hFFFF_FFFF;
            run_idx        <= 8'd0;
            cnt            <= 9'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_addr <= hash_addr;
                        res_addr  <= result_addr;
                        tgt       <= target;
                        run_min   <= 32'hFFFF_FFFF;
                        run_idx   <= 8'd0;
                        cnt       <= 9'd0;
                        mem_addr  <= hash_addr;
                        done      <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    run_min <= next_min;
                    run_idx <= next_idx;
                    cnt     <= cnt + 9'd1;
                    if (cnt + 9'd1 < LAST) begin
                        mem_addr <= base_addr + 16'(cnt) + 16'd1;
                    end
                    if (cnt == LAST) begin
                        mem_we         <= 1'b1;
                        mem_addr       <= res_addr;
                        mem_write_data <= next_min;
                        state          <= WR_HASH;
                    end
                end
                WR_HASH: begin
                    mem_addr       <= res_addr + 16'd1;
                    mem_write_data <= {(run_min < tgt), 23'd0, run_idx};
                    state          <= WR_IDX;
                end
                WR_IDX: begin
                    mem_we     <= 1'b0;
                    best_hash  <= run_min;
                    best_nonce <= run_idx;
                    found      <= (run_min < tgt);
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitcoin_nonce_select.sv
// tb/tb_bitcoin_nonce_select.sv - scoreboard bench for bitcoin_nonce_select
module tb_bitcoin_nonce_select;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] hash_addr = 16'd0;
    logic [15:0] result_addr = 16'd0;
    logic [31:0] target = 32'd0;
    logic        done, found, mem_clk, mem_we;
    logic [31:0] best_hash, mem_write_data;
    logic [7:0]  best_nonce;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:65535];

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [31:0] bh;
        logic [7:0]  bn;
        logic        f;
        int          lat;
    } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];

    int checks = 0;
    int failures = 0;

    bitcoin_nonce_select #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .hash_addr(hash_addr), .result_addr(result_addr), .target(target),
        .done(done), .found(found), .best_hash(best_hash), .best_nonce(best_nonce),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // read-only memory image; DUT writes are checked through the scoreboard
    always @(posedge mem_clk) mem_read_data <= mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_scan(input logic [15:0] ra, input logic [31:0] bh,
                               input logic [7:0] bn, input logic f);
        wr_t  w;
        res_t r;
        w.a = ra;         w.d = bh;                        wr_q.push_back(w);
        w.a = ra + 16'd1; w.d = {f, 23'd0, bn};            wr_q.push_back(w);
        r.bh = bh; r.bn = bn; r.f = f; r.lat = N + 3;      res_q.push_back(r);
    endtask

    task automatic go(input logic [15:0] ha, input logic [15:0] ra, input logic [31:0] tg);
        @(posedge clk); #1;
        hash_addr = ha; result_addr = ra; target = tg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_found"}, {31'd0, found}, 32'd0);
        chk({tag, "_best_hash"}, best_hash, 32'd0);
        chk({tag, "_best_nonce"}, {24'd0, best_nonce}, 32'd0);
    endtask

    // monitor: pops expected writes on mem_we, expected results when done rises
    logic prev_done = 1'b1;
    int   low_cycles = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_done  = 1'b1;
            low_cycles = 0;
        end else begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write_addr", {16'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", {16'd0, mem_addr}, {16'd0, w.a});
                    chk("wr_data", mem_write_data, w.d);
                end
            end
            if (!done) begin
                low_cycles++;
            end else if (!prev_done) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done_rise", 32'd1, 32'd0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("best_hash", best_hash, r.bh);
                    chk("best_nonce", {24'd0, best_nonce}, {24'd0, r.bn});
                    chk("found", {31'd0, found}, {31'd0, r.f});
                    chk("busy_cycles", low_cycles, r.lat);
                end
                low_cycles = 0;
            end
            prev_done = done;
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        for (int k = 0; k < 16; k++) mem[16'h0100 + k] = 32'hF000_0000 - 32'(k) * 32'h0100_0000;
        for (int k = 0; k < 16; k++) mem[16'h0300 + k] = 32'hFFFF_0000;
        mem[16'h0303] = 32'h0000_1234;
        mem[16'h0309] = 32'h0000_1234;
        for (int k = 0; k < 16; k++) begin
            logic [15:0] a;
            a = 16'hFFF8 + 16'(k);
            mem[a] = 32'h5000_0000 + 32'(k) * 32'h100;
        end
        mem[16'h0002] = 32'h0000_0042;

        // reset state
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", mem_write_data, 32'd0);

        // descending hashes, nothing below target 0
        expect_scan(16'h0200, 32'hE100_0000, 8'd15, 1'b0);
        go(16'h0100, 16'h0200, 32'h0);
        wait_done();

        // tie between idx 3 and 9
        expect_scan(16'h0400, 32'h0000_1234, 8'd3, 1'b0);
        go(16'h0300, 16'h0400, 32'h0);
        wait_done();

        // target equal to minimum is not found, one above is
        expect_scan(16'h0400, 32'h0000_1234, 8'd3, 1'b0);
        go(16'h0300, 16'h0400, 32'h0000_1234);
        wait_done();
        expect_scan(16'h0400, 32'h0000_1234, 8'd3, 1'b1);
        go(16'h0300, 16'h0400, 32'h0000_1235);
        wait_done();

        // address wrap on reads and on the result record
        expect_scan(16'hFFFF, 32'h0000_0042, 8'd10, 1'b1);
        go(16'hFFF8, 16'hFFFF, 32'h0000_0100);
        wait_done();

        // reset during READ cycle 5 aborts with no writes
        go(16'h0100, 16'h0200, 32'h0);
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midscan_reset");
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_idle_done", {31'd0, done}, 32'd1);

        // fresh scan with a start pulse while busy that must be ignored
        expect_scan(16'h0200, 32'hE100_0000, 8'd15, 1'b0);
        go(16'h0100, 16'h0200, 32'h0);
        repeat (3) @(posedge clk);
        #1 hash_addr = 16'h0300; result_addr = 16'h0500; target = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();

        repeat (3) @(negedge clk);
        chk("pending_writes", wr_q.size(), 32'd0);
        chk("pending_results", res_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
